msgst_cmd_bram_slv: RTL and testbench

MSGST_CMD_BRAM_SLV -- requirements
Module: msgst_cmd_bram_slv

---
 rtl/msgst_cmd_bram_slv.sv | 229 ++++++++++++++++++++++
 tb/tb_msgst_cmd_bram_slv.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msgst_cmd_bram_slv.sv
// MSGST command store: AXI4-Lite slave in front of a byte-writable word array.
// Descriptor decode is built only when MSGST_DESC_DECODE_EN is defined.

module msgst_cmd_bram_slv #(
   parameter int DEPTH_WORDS    = 64,
   parameter int WORDS_PER_DESC = 6
) (
   input  logic        fabric_clk,
   input  logic        fabric_rst,
   input  logic [31:0] S_AXI_awaddr,
   input  logic [2:0]  S_AXI_awprot,
   input  logic        S_AXI_awvalid,
   output logic        S_AXI_awready,
   input  logic [31:0] S_AXI_wdata,
   input  logic [3:0]  S_AXI_wstrb,
   input  logic        S_AXI_wvalid,
   output logic        S_AXI_wready,
   output logic [1:0]  S_AXI_bresp,
   output logic        S_AXI_bvalid,
   input  logic        S_AXI_bready,
   input  logic [31:0] S_AXI_araddr,
   input  logic [2:0]  S_AXI_arprot,
   input  logic        S_AXI_arvalid,
   output logic        S_AXI_arready,
   output logic [31:0] S_AXI_rdata,
   output logic [1:0]  S_AXI_rresp,
   output logic        S_AXI_rvalid,
   input  logic        S_AXI_rready,
   input  logic        desc_clear,
   output logic        desc_valid,
   output logic [8:0]  desc_pld_length,
   output logic [4:0]  desc_csi_dst,
   output logic [11:0] desc_cookie,
   output logic [6:0]  desc_count
);

   localparam int         IDX_W       = $clog2(DEPTH_WORDS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic             aw_held_q;
   logic [IDX_W-1:0] aw_idx_q;
   logic             aw_oor_q;
   logic             w_held_q;
   logic [31:0]      w_data_q;
   logic [3:0]       w_strb_q;
   logic             bvalid_q;
   logic [1:0]       bresp_q;
   logic             rvalid_q;
   logic             rd_oor_q;
   logic [31:0]      rd_word_q;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             aw_hs;
   logic             w_hs;
   logic             ar_hs;
   logic             wr_commit;
   logic             wr_ok;
   logic [IDX_W-1:0] ar_idx;
   logic             ar_oor;

   assign S_AXI_awready = !aw_held_q && !bvalid_q;
   assign S_AXI_wready  = !w_held_q && !bvalid_q;
   assign S_AXI_arready = !rvalid_q;

   assign aw_hs     = S_AXI_awvalid && S_AXI_awready;
   assign w_hs      = S_AXI_wvalid && S_AXI_wready;
   assign ar_hs     = S_AXI_arvalid && S_AXI_arready;
   assign wr_commit = aw_held_q && w_held_q;
   // A commit coinciding with reset is treated as discarded, array included.
   assign wr_ok     = wr_commit && !aw_oor_q && !fabric_rst;
   assign ar_idx    = S_AXI_araddr[IDX_W+1:2];
   assign ar_oor    = |S_AXI_araddr[31:IDX_W+2];

   always_ff @(posedge fabric_clk) begin
      if (fabric_rst) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         aw_oor_q  <= 1'b0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= S_AXI_awaddr[IDX_W+1:2];
            aw_oor_q  <= |S_AXI_awaddr[31:IDX_W+2];
         end else if (wr_commit) begin
            aw_held_q <= 1'b0;
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= S_AXI_wdata;
            w_strb_q <= S_AXI_wstrb;
         end else if (wr_commit) begin
            w_held_q <= 1'b0;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
         end else if (bvalid_q && S_AXI_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
         end
      end
   end

   // Storage has no reset; the read port sees pre-write data on a same-word collision.
   always_ff @(posedge fabric_clk) begin
      if (wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb_q[b]) begin
               mem_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
            end
         end
      end
      if (ar_hs) begin
         rd_word_q <= mem_q[ar_idx];
      end
   end

   always_ff @(posedge fabric_clk) begin
      if (fabric_rst) begin
         rvalid_q <= 1'b0;
         rd_oor_q <= 1'b0;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rd_oor_q <= ar_oor;
      end else if (rvalid_q && S_AXI_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign S_AXI_bvalid = bvalid_q;
   assign S_AXI_bresp  = bresp_q;
   assign S_AXI_rvalid = rvalid_q;
   assign S_AXI_rdata  = (rvalid_q && !rd_oor_q) ? rd_word_q : 32'd0;
   assign S_AXI_rresp  = (rvalid_q && rd_oor_q) ? RESP_SLVERR : RESP_OKAY;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr[1:0], S_AXI_araddr[1:0]};

`ifdef MSGST_DESC_DECODE_EN
   localparam int CNT_W = $clog2(WORDS_PER_DESC + 1);

   logic [31:0]      wr_mask;
   logic [31:0]      shadow_q [3];
   logic [31:0]      shadow_d [3];
   logic [CNT_W-1:0] word_cnt_q;
   logic             desc_last;
   logic             desc_valid_q;
   logic [8:0]       pld_length_q;
   logic [4:0]       csi_dst_q;
   logic [11:0]      cookie_q;
   logic [6:0]       desc_count_q;

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wr_mask[8*gi +: 8] = {8{w_strb_q[gi]}};
   end

   // Mirror of words 0..2 so the fields can be taken post-write without a second array port.
   for (gi = 0; gi < 3; gi++) begin : g_shadow
      assign shadow_d[gi] = (wr_ok && aw_idx_q == IDX_W'(gi))
                          ? ((shadow_q[gi] & ~wr_mask) | (w_data_q & wr_mask))
                          : shadow_q[gi];
   end

   always_ff @(posedge fabric_clk) begin
      for (int k = 0; k < 3; k++) begin
         shadow_q[k] <= shadow_d[k];
      end
   end

   assign desc_last = (word_cnt_q == CNT_W'(WORDS_PER_DESC - 1));

   always_ff @(posedge fabric_clk) begin
      if (fabric_rst) begin
         word_cnt_q   <= '0;
         desc_valid_q <= 1'b0;
         pld_length_q <= '0;
         csi_dst_q    <= '0;
         cookie_q     <= '0;
         desc_count_q <= '0;
      end else begin
         desc_valid_q <= 1'b0;
         if (desc_clear) begin
            word_cnt_q   <= '0;
            desc_count_q <= '0;
         end else if (wr_ok) begin
            if (desc_last) begin
               word_cnt_q   <= '0;
               desc_valid_q <= 1'b1;
               desc_count_q <= desc_count_q + 7'd1;
               pld_length_q <= shadow_d[0][8:0];
               csi_dst_q    <= shadow_d[1][26:22];
               cookie_q     <= shadow_d[2][12:1];
            end else begin
               word_cnt_q <= word_cnt_q + 1'b1;
            end
         end
      end
   end

   assign desc_valid      = desc_valid_q;
   assign desc_pld_length = pld_length_q;
   assign desc_csi_dst    = csi_dst_q;
   assign desc_cookie     = cookie_q;
   assign desc_count      = desc_count_q;

   logic unused_desc;
   assign unused_desc = ^{shadow_d[0][31:9], shadow_d[1][31:27], shadow_d[1][21:0],
                          shadow_d[2][31:13], shadow_d[2][0]};
`else
   assign desc_valid      = 1'b0;
   assign desc_pld_length = '0;
   assign desc_csi_dst    = '0;
   assign desc_cookie     = '0;
   assign desc_count      = '0;

   logic        unused_desc;
   logic [31:0] unused_wpd;
   assign unused_desc = desc_clear;
   assign unused_wpd  = WORDS_PER_DESC;
`endif

endmodule

// File: tb/tb_msgst_cmd_bram_slv.sv
// Randomized self-checking bench for msgst_cmd_bram_slv against an array-based reference model.
// Descriptor checks follow MSGST_DESC_DECODE_EN the same way the design does.

module tb_msgst_cmd_bram_slv;

   logic        fabric_clk = 1'b0;
   logic        fabric_rst = 1'b1;
   logic [31:0] S_AXI_awaddr = '0;
   logic [2:0]  S_AXI_awprot = '0;
   logic        S_AXI_awvalid = 1'b0;
   logic        S_AXI_awready;
   logic [31:0] S_AXI_wdata = '0;
   logic [3:0]  S_AXI_wstrb = '0;
   logic        S_AXI_wvalid = 1'b0;
   logic        S_AXI_wready;
   logic [1:0]  S_AXI_bresp;
   logic        S_AXI_bvalid;
   logic        S_AXI_bready = 1'b0;
   logic [31:0] S_AXI_araddr = '0;
   logic [2:0]  S_AXI_arprot = '0;
   logic        S_AXI_arvalid = 1'b0;
   logic        S_AXI_arready;
   logic [31:0] S_AXI_rdata;
   logic [1:0]  S_AXI_rresp;
   logic        S_AXI_rvalid;
   logic        S_AXI_rready = 1'b0;
   logic        desc_clear = 1'b0;
   logic        desc_valid;
   logic [8:0]  desc_pld_length;
   logic [4:0]  desc_csi_dst;
   logic [11:0] desc_cookie;
   logic [6:0]  desc_count;

   int checks = 0;
   int errors = 0;
   int desc_pulses = 0;
   logic [31:0] ref_mem [64];

   msgst_cmd_bram_slv #(.DEPTH_WORDS(64), .WORDS_PER_DESC(6)) dut (
      .fabric_clk(fabric_clk), .fabric_rst(fabric_rst),
      .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
      .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
      .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
      .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
      .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
      .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
      .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
      .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
      .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
      .desc_clear(desc_clear), .desc_valid(desc_valid),
      .desc_pld_length(desc_pld_length), .desc_csi_dst(desc_csi_dst),
      .desc_cookie(desc_cookie), .desc_count(desc_count)
   );

   always #5 fabric_clk = ~fabric_clk;

   always @(posedge fabric_clk) begin
      if (!fabric_rst && desc_valid === 1'b1) desc_pulses <= desc_pulses + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge fabric_clk);
      #1;
   endtask

   function automatic bit in_range(input logic [31:0] a);
      return a < 32'd256;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (in_range(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
      bit aw_done = 0;
      bit w_done = 0;
      bit aw_fire, w_fire;
      int c = 0;
      resp = 2'bxx;
      S_AXI_awaddr = a; S_AXI_wdata = d; S_AXI_wstrb = s; S_AXI_awprot = 3'($urandom);
      while (!(aw_done && w_done) && c < 200) begin
         S_AXI_awvalid = !aw_done && c >= aw_dly;
         S_AXI_wvalid  = !w_done && c >= w_dly;
         aw_fire = S_AXI_awvalid && S_AXI_awready;
         w_fire  = S_AXI_wvalid && S_AXI_wready;
         tick();
         c++;
         if (aw_fire) aw_done = 1;
         if (w_fire) w_done = 1;
      end
      S_AXI_awvalid = 1'b0;
      S_AXI_wvalid  = 1'b0;
      S_AXI_bready  = 1'b1;
      c = 0;
      while (S_AXI_bvalid !== 1'b1 && c < 200) begin
         tick();
         c++;
      end
      if (S_AXI_bvalid !== 1'b1) begin
         $display("FAIL wr_timeout addr=%h got bvalid=%b required 1", a, S_AXI_bvalid);
         errors++;
         checks++;
      end else begin
         resp = S_AXI_bresp;
         tick();
      end
      S_AXI_bready = 1'b0;
      model_write(a, d, s);
      $display("WR addr=%h data=%h strb=%b resp=%b", a, d, s, resp);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
      bit fire = 0;
      int c = 0;
      data = 'x;
      resp = 2'bxx;
      S_AXI_araddr = a; S_AXI_arprot = 3'($urandom);
      while (!fire && c < 200) begin
         S_AXI_arvalid = 1'b1;
         fire = S_AXI_arready;
         tick();
         c++;
      end
      S_AXI_arvalid = 1'b0;
      S_AXI_rready  = 1'b1;
      c = 0;
      while (S_AXI_rvalid !== 1'b1 && c < 200) begin
         tick();
         c++;
      end
      if (S_AXI_rvalid !== 1'b1) begin
         $display("FAIL rd_timeout addr=%h got rvalid=%b required 1", a, S_AXI_rvalid);
         errors++;
         checks++;
      end else begin
         data = S_AXI_rdata;
         resp = S_AXI_rresp;
         tick();
      end
      S_AXI_rready = 1'b0;
      $display("RD addr=%h data=%h resp=%b", a, data, resp);
   endtask

   task automatic test_reset();
      fabric_rst = 1'b1;
      repeat (3) tick();
      if ({S_AXI_bvalid, S_AXI_rvalid, desc_valid} !== 3'b000) begin
         $display("FAIL rst_valids got %b required 000", {S_AXI_bvalid, S_AXI_rvalid, desc_valid});
         errors++;
      end
      checks++;
      if ({S_AXI_bresp, S_AXI_rresp} !== 4'b0000) begin
         $display("FAIL rst_resp got %b required 0000", {S_AXI_bresp, S_AXI_rresp});
         errors++;
      end
      checks++;
      if (S_AXI_rdata !== 32'd0) begin
         $display("FAIL rst_rdata got %h required 0", S_AXI_rdata);
         errors++;
      end
      checks++;
      if ({desc_pld_length, desc_csi_dst, desc_cookie, desc_count} !== 33'd0) begin
         $display("FAIL rst_desc got %h required 0", {desc_pld_length, desc_csi_dst, desc_cookie, desc_count});
         errors++;
      end
      checks++;
      fabric_rst = 1'b0;
      tick();
      if ({S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 3'b111) begin
         $display("FAIL rst_ready got %b required 111", {S_AXI_awready, S_AXI_wready, S_AXI_arready});
         errors++;
      end
      checks++;
   endtask

   task automatic test_w_before_aw();
      logic [1:0] r;
      logic [31:0] d;
      do_write(32'h10, 32'h0000000A, 4'hF, 3, 0, r);
      if (r !== 2'b00) begin
         $display("FAIL wfirst_bresp got %b required 00", r);
         errors++;
      end
      checks++;
      if (S_AXI_bvalid !== 1'b0) begin
         $display("FAIL wfirst_single_b got bvalid=%b required 0", S_AXI_bvalid);
         errors++;
      end
      checks++;
      do_read(32'h10, d, r);
      if (d !== 32'h0000000A || r !== 2'b00) begin
         $display("FAIL wfirst_read got %h/%b required 0000000a/00", d, r);
         errors++;
      end
      checks++;
   endtask

   task automatic test_wstrb();
      logic [1:0] r;
      logic [31:0] d;
      do_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 1, r);
      do_write(32'h04, 32'h12345678, 4'b0101, 1, 0, r);
      do_read(32'h04, d, r);
      if (d !== 32'hFF34FF78 || d !== ref_mem[1]) begin
         $display("FAIL wstrb_read got %h required ff34ff78", d);
         errors++;
      end
      checks++;
   endtask

   task automatic test_out_of_range();
      logic [1:0] r;
      logic [31:0] d;
      do_write(32'h00, 32'hA5A50F0F, 4'hF, 0, 0, r);
      do_write(32'h100, 32'h5A5AF0F0, 4'hF, 0, 0, r);
      if (r !== 2'b10) begin
         $display("FAIL oor_bresp got %b required 10", r);
         errors++;
      end
      checks++;
      do_read(32'h100, d, r);
      if (d !== 32'd0 || r !== 2'b10) begin
         $display("FAIL oor_read got %h/%b required 00000000/10", d, r);
         errors++;
      end
      checks++;
      do_read(32'h00, d, r);
      if (d !== 32'hA5A50F0F || r !== 2'b00) begin
         $display("FAIL oor_unchanged got %h/%b required a5a50f0f/00", d, r);
         errors++;
      end
      checks++;
   endtask

   task automatic test_rw_collision();
      logic [1:0] r;
      logic [31:0] d;
      logic [31:0] nv;
      nv = $urandom | 32'h100;
      do_write(32'h08, 32'h5, 4'hF, 0, 0, r);
      S_AXI_awaddr = 32'h08; S_AXI_wdata = nv; S_AXI_wstrb = 4'hF;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
      if ({S_AXI_awready, S_AXI_wready} !== 2'b11) begin
         $display("FAIL coll_ready got %b required 11", {S_AXI_awready, S_AXI_wready});
         errors++;
      end
      checks++;
      tick();
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
      S_AXI_araddr = 32'h08; S_AXI_arvalid = 1'b1;
      tick();
      S_AXI_arvalid = 1'b0;
      if (S_AXI_rvalid !== 1'b1 || S_AXI_bvalid !== 1'b1 || S_AXI_rdata !== 32'h5) begin
         $display("FAIL coll_old got rv=%b bv=%b rdata=%h required 1/1/00000005",
                  S_AXI_rvalid, S_AXI_bvalid, S_AXI_rdata);
         errors++;
      end
      checks++;
      S_AXI_rready = 1'b1; S_AXI_bready = 1'b1;
      tick();
      S_AXI_rready = 1'b0; S_AXI_bready = 1'b0;
      model_write(32'h08, nv, 4'hF);
      $display("WR addr=00000008 data=%h strb=1111 (collision)", nv);
      do_read(32'h08, d, r);
      if (d !== ref_mem[2]) begin
         $display("FAIL coll_new got %h required %h", d, ref_mem[2]);
         errors++;
      end
      checks++;
   endtask

   task automatic test_backpressure_reset();
      logic [1:0] r;
      logic [31:0] d;
      logic [31:0] v;
      v = $urandom;
      S_AXI_awaddr = 32'h0C; S_AXI_wdata = v; S_AXI_wstrb = 4'hF;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
      tick();
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
      tick();
      model_write(32'h0C, v, 4'hF);
      for (int i = 0; i < 10; i++) begin
         if ({S_AXI_bvalid, S_AXI_awready, S_AXI_wready} !== 3'b100) begin
            $display("FAIL bp_hold cycle %0d got bv/awr/wr=%b required 100", i,
                     {S_AXI_bvalid, S_AXI_awready, S_AXI_wready});
            errors++;
         end
         checks++;
         tick();
      end
      S_AXI_bready = 1'b1;
      tick();
      S_AXI_bready = 1'b0;
      if ({S_AXI_bvalid, S_AXI_awready, S_AXI_wready} !== 3'b011) begin
         $display("FAIL bp_release got %b required 011", {S_AXI_bvalid, S_AXI_awready, S_AXI_wready});
         errors++;
      end
      checks++;
      do_read(32'h0C, d, r);
      if (d !== v) begin
         $display("FAIL bp_read got %h required %h", d, v);
         errors++;
      end
      checks++;
      v = $urandom;
      S_AXI_awaddr = 32'h18; S_AXI_wdata = v; S_AXI_wstrb = 4'hF;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
      tick();
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
      tick();
      model_write(32'h18, v, 4'hF);
      if (S_AXI_bvalid !== 1'b1) begin
         $display("FAIL rst_mid_pre got bvalid=%b required 1", S_AXI_bvalid);
         errors++;
      end
      checks++;
      fabric_rst = 1'b1;
      tick();
      if ({S_AXI_bvalid, S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 4'b0111) begin
         $display("FAIL rst_mid_b got %b required 0111",
                  {S_AXI_bvalid, S_AXI_awready, S_AXI_wready, S_AXI_arready});
         errors++;
      end
      checks++;
      fabric_rst = 1'b0;
      tick();
      S_AXI_araddr = 32'h18; S_AXI_arvalid = 1'b1;
      tick();
      S_AXI_arvalid = 1'b0;
      fabric_rst = 1'b1;
      tick();
      if (S_AXI_rvalid !== 1'b0 || S_AXI_rdata !== 32'd0) begin
         $display("FAIL rst_mid_r got rv=%b rdata=%h required 0/00000000", S_AXI_rvalid, S_AXI_rdata);
         errors++;
      end
      checks++;
      fabric_rst = 1'b0;
      tick();
      do_read(32'h18, d, r);
      if (d !== v) begin
         $display("FAIL rst_mid_array got %h required %h", d, v);
         errors++;
      end
      checks++;
   endtask

   task automatic test_random();
      logic [1:0] r;
      logic [31:0] d;
      logic [31:0] a;
      logic [3:0] s;
      for (int w = 0; w < 64; w++) begin
         do_write(32'(w * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), r);
         if (r !== 2'b00) begin
            $display("FAIL fill_bresp word %0d got %b required 00", w, r);
            errors++;
         end
         checks++;
      end
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
         else a = {24'd0, 6'($urandom), 2'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            s = 4'($urandom);
            do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
            if (r !== (in_range(a) ? 2'b00 : 2'b10)) begin
               $display("FAIL rnd_bresp addr=%h got %b required %b", a, r, in_range(a) ? 2'b00 : 2'b10);
               errors++;
            end
            checks++;
         end else begin
            do_read(a, d, r);
            if (d !== (in_range(a) ? ref_mem[a[7:2]] : 32'd0) || r !== (in_range(a) ? 2'b00 : 2'b10)) begin
               $display("FAIL rnd_read addr=%h got %h/%b required %h/%b", a, d, r,
                        in_range(a) ? ref_mem[a[7:2]] : 32'd0, in_range(a) ? 2'b00 : 2'b10);
               errors++;
            end
            checks++;
         end
      end
   endtask

`ifdef MSGST_DESC_DECODE_EN
   task automatic test_desc();
      logic [31:0] words [6];
      logic [1:0] r;
      int p0;
      words = '{32'h100, 32'h010F0000, 32'h00003123, 32'h01F00000, 32'h0, 32'h0};
      desc_clear = 1'b1;
      tick();
      desc_clear = 1'b0;
      if (desc_count !== 7'd0) begin
         $display("FAIL desc_clear_count got %0d required 0", desc_count);
         errors++;
      end
      checks++;
      p0 = desc_pulses;
      do_write(32'h104, 32'hDEAD, 4'hF, 0, 0, r);
      for (int i = 0; i < 6; i++) begin
         do_write(32'(4 * i), words[i], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), r);
         if (i == 4 && desc_pulses != p0) begin
            $display("FAIL desc_early got %0d pulses required 0", desc_pulses - p0);
            errors++;
         end
         if (i == 4) checks++;
      end
      tick();
      if (desc_pulses != p0 + 1 || desc_count !== 7'd1) begin
         $display("FAIL desc_pulse got pulses=%0d count=%0d required 1/1", desc_pulses - p0, desc_count);
         errors++;
      end
      checks++;
      if (desc_pld_length !== 9'h100 || desc_csi_dst !== 5'h4 || desc_cookie !== 12'h891) begin
         $display("FAIL desc_fields got %h/%h/%h required 100/04/891", desc_pld_length, desc_csi_dst, desc_cookie);
         errors++;
      end
      checks++;
      for (int i = 0; i < 5; i++) do_write(32'(4 * i), $urandom, 4'hF, 0, 0, r);
      p0 = desc_pulses;
      S_AXI_awaddr = 32'h14; S_AXI_wdata = 32'h77; S_AXI_wstrb = 4'hF;
      S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
      tick();
      S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
      desc_clear = 1'b1;
      tick();
      desc_clear = 1'b0;
      S_AXI_bready = 1'b1;
      tick();
      S_AXI_bready = 1'b0;
      model_write(32'h14, 32'h77, 4'hF);
      if (desc_count !== 7'd0 || desc_pulses != p0) begin
         $display("FAIL desc_clear_prio got count=%0d pulses=%0d required 0/0", desc_count, desc_pulses - p0);
         errors++;
      end
      checks++;
      for (int i = 0; i < 6; i++) do_write(32'(4 * i), $urandom, 4'hF, 0, 0, r);
      tick();
      if (desc_pulses != p0 + 1 || desc_count !== 7'd1) begin
         $display("FAIL desc_after_clear got pulses=%0d count=%0d required 1/1", desc_pulses - p0, desc_count);
         errors++;
      end
      checks++;
      if (desc_pld_length !== ref_mem[0][8:0] || desc_csi_dst !== ref_mem[1][26:22] ||
          desc_cookie !== ref_mem[2][12:1]) begin
         $display("FAIL desc_rnd_fields got %h/%h/%h required %h/%h/%h", desc_pld_length, desc_csi_dst,
                  desc_cookie, ref_mem[0][8:0], ref_mem[1][26:22], ref_mem[2][12:1]);
         errors++;
      end
      checks++;
   endtask
`else
   task automatic test_desc();
      logic [1:0] r;
      desc_clear = 1'b1;
      tick();
      desc_clear = 1'b0;
      for (int i = 0; i < 6; i++) do_write(32'(4 * i), $urandom, 4'hF, 0, 0, r);
      tick();
      if (desc_pulses != 0 || desc_count !== 7'd0) begin
         $display("FAIL desc_off_pulse got pulses=%0d count=%0d required 0/0", desc_pulses, desc_count);
         errors++;
      end
      checks++;
      if ({desc_pld_length, desc_csi_dst, desc_cookie} !== 26'd0) begin
         $display("FAIL desc_off_fields got %h required 0", {desc_pld_length, desc_csi_dst, desc_cookie});
         errors++;
      end
      checks++;
   endtask
`endif

   initial begin
      test_reset();
      test_w_before_aw();
      test_wstrb();
      test_out_of_range();
      test_rw_collision();
      test_backpressure_reset();
      test_random();
      test_desc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
